// File: rtl/sram_1rw1r_model_pkg.sv
// Shared constants and helpers for the 1RW+1R SRAM model.
//   COLLISION_OLD / COLLISION_NEW : port-1 read policy on a same-edge port-0 write
//   MAX_READ_LATENCY              : deepest supported read pipeline
//   calc_num_wmasks()             : number of write-mask lanes per word
package sram_model_pkg;

    localparam int unsigned COLLISION_OLD    = 0;
    localparam int unsigned COLLISION_NEW    = 1;
    localparam int unsigned MAX_READ_LATENCY = 3;

    function automatic int unsigned calc_num_wmasks(input int unsigned data_width,
                                                    input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/sram_1rw1r_model_if.sv
// Bus bundle for the 1RW+1R SRAM model.
//   Port 0 (read/write): csb0, web0, wmask0, spare_wen0, addr0, din0 -> dout0, dout0_valid, err0
//   Port 1 (read only) : csb1, addr1 -> dout1, dout1_valid, err1, collision1
//   master: the requester side; slave: the memory side.
interface sram_1rw1r_model_if
    import sram_model_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned SPARE_BITS = 1,
    parameter int unsigned ADDR_WIDTH = 9
);
    localparam int unsigned NUM_WMASKS = calc_num_wmasks(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + SPARE_BITS;

    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic                  spare_wen0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [WORD_WIDTH-1:0] din0;
    logic [WORD_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  err0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [WORD_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  err1;
    logic                  collision1;

    modport master (
        output csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, err0, dout1, dout1_valid, err1, collision1
    );

    modport slave (
        input  csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, err0, dout1, dout1_valid, err1, collision1
    );

endinterface

// File: rtl/sram_1rw1r_model_rd_pipe.sv
// Read-result delay line for one SRAM read port.
//   clk, rst_n          : clock, asynchronous active-low reset (clears every stage)
//   in_valid/in_data    : read result sampled at the request edge
//   in_flags            : per-read side info (err, collision), meaningful only with in_valid
//   out_valid/out_data  : result LATENCY edges later; out_data holds when no result arrives
//   out_flags           : side info aligned with out_valid, forced low otherwise
module sram_rd_pipe #(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned FLAG_WIDTH = 1,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [FLAG_WIDTH-1:0] in_flags,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [FLAG_WIDTH-1:0] out_flags
);
    logic [LATENCY-1:0]    valid_q;
    logic [WIDTH-1:0]      data_q  [LATENCY];
    logic [FLAG_WIDTH-1:0] flags_q [LATENCY];

    // Inner stages shift freely; only the last stage is gated by valid so the
    // visible data holds its previous value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i]  <= '0;
                flags_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            flags_q[0] <= in_valid ? in_flags : '0;
            if (LATENCY > 1 || in_valid)
                data_q[0] <= in_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                flags_q[i] <= flags_q[i-1];
                if (i < LATENCY - 1 || valid_q[i-1])
                    data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
    assign out_flags = flags_q[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_model.sv
// Parametrised single-clock SRAM with one read/write port and one read-only port.
//   clk0   : clock, all activity on the rising edge
//   rst0_n : asynchronous active-low reset of outputs and read pipelines (array untouched)
//   bus    : port-0 / port-1 request and response signals (see sram_1rw1r_model_if)
// Lane-masked writes with a separate spare-bit enable, configurable read latency,
// out-of-range error pulses and a selectable same-address collision policy.
module sram_1rw1r_model
    import sram_model_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LANE_WIDTH     = 8,
    parameter int unsigned NUM_WMASKS     = calc_num_wmasks(DATA_WIDTH, LANE_WIDTH),
    parameter int unsigned SPARE_BITS     = 1,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned RAM_DEPTH      = 512,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned COLLISION_MODE = COLLISION_OLD
) (
    input  logic              clk0,
    input  logic              rst0_n,
    sram_1rw1r_model_if.slave bus
);
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + SPARE_BITS;

    logic [WORD_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  in_range0;
    logic                  in_range1;
    logic                  wr_en0;
    logic                  rd_en0;
    logic                  rd_en1;
    logic                  hit1;
    logic                  wr_err_q;
    logic [WORD_WIDTH-1:0] bit_en;
    logic [WORD_WIDTH-1:0] old0;
    logic [WORD_WIDTH-1:0] merged0;
    logic [WORD_WIDTH-1:0] rd_word0;
    logic [WORD_WIDTH-1:0] rd_word1;
    logic                  rd0_err;
    logic [1:0]            rd1_flags;

    assign in_range0 = 32'(bus.addr0) < RAM_DEPTH;
    assign in_range1 = 32'(bus.addr1) < RAM_DEPTH;
    assign wr_en0    = !bus.csb0 && !bus.web0 && in_range0;
    assign rd_en0    = !bus.csb0 && bus.web0;
    assign rd_en1    = !bus.csb1;
    assign hit1      = wr_en0 && rd_en1 && in_range1 && (bus.addr1 == bus.addr0);

    // Expand lane mask and spare enable into a per-bit write enable.
    always_comb begin
        bit_en = '0;
        for (int unsigned i = 0; i < NUM_WMASKS; i++)
            bit_en[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{bus.wmask0[i]}};
        for (int unsigned b = DATA_WIDTH; b < WORD_WIDTH; b++)
            bit_en[b] = bus.spare_wen0;
    end

    assign old0     = in_range0 ? mem[bus.addr0] : '0;
    assign merged0  = (old0 & ~bit_en) | (bus.din0 & bit_en);
    assign rd_word0 = old0;

    always_comb begin
        rd_word1 = '0;
        if (in_range1)
            rd_word1 = (hit1 && COLLISION_MODE == COLLISION_NEW) ? merged0 : mem[bus.addr1];
    end

    always_ff @(posedge clk0) begin
        if (wr_en0)
            mem[bus.addr0] <= merged0;
    end

    // Dropped (out-of-range) writes report err0 on the cycle after the edge.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n)
            wr_err_q <= 1'b0;
        else
            wr_err_q <= !bus.csb0 && !bus.web0 && !in_range0;
    end

    sram_rd_pipe #(
        .WIDTH      (WORD_WIDTH),
        .FLAG_WIDTH (1),
        .LATENCY    (READ_LATENCY)
    ) u_pipe0 (
        .clk       (clk0),
        .rst_n     (rst0_n),
        .in_valid  (rd_en0),
        .in_data   (rd_word0),
        .in_flags  (!in_range0),
        .out_valid (bus.dout0_valid),
        .out_data  (bus.dout0),
        .out_flags (rd0_err)
    );

    sram_rd_pipe #(
        .WIDTH      (WORD_WIDTH),
        .FLAG_WIDTH (2),
        .LATENCY    (READ_LATENCY)
    ) u_pipe1 (
        .clk       (clk0),
        .rst_n     (rst0_n),
        .in_valid  (rd_en1),
        .in_data   (rd_word1),
        .in_flags  ({hit1, !in_range1}),
        .out_valid (bus.dout1_valid),
        .out_data  (bus.dout1),
        .out_flags (rd1_flags)
    );

    assign bus.err0       = rd0_err | wr_err_q;
    assign bus.err1       = rd1_flags[0];
    assign bus.collision1 = rd1_flags[1];

endmodule

// File: doc/sram_1rw1r_model.md
Name: sram_1rw1r_model

Overview:
- Parametrised single-clock SRAM model with one read/write port (port 0) and one read-only port (port 1).
- Byte-lane write masking is generalised to any lane width. Optional spare bits have their own enable.
- Read latency is configurable, each read port reports a valid strobe, and same-address collisions between ports follow a defined policy.
- Used by user-project RTL and benches in place of fixed-geometry macro models. Synthesisable; the array itself is never reset.

Parameters:
- DATA_WIDTH, 32: payload bits per word, excluding spare bits.
- LANE_WIDTH, 8: bits per write-mask lane. DATA_WIDTH must be a multiple of LANE_WIDTH.
- NUM_WMASKS, DATA_WIDTH/LANE_WIDTH: derived; do not override.
- SPARE_BITS, 1: extra bits per word, written only when spare_wen0=1. 0 is legal and removes the spare bits.
- ADDR_WIDTH, 9: address bits.
- RAM_DEPTH, 512: number of words, at most 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from sampled read request to dout valid. Legal values 1..3.
- COLLISION_MODE, 0: policy for a port-1 read of the address port 0 writes in the same cycle. 0 = port 1 returns old data; 1 = port 1 returns new (merged) data.

Ports:
- clk0  in  1  sole clock; all activity on the rising edge.
- rst0_n  in  1  asynchronous active-low reset.
- csb0  in  1  port 0 active-low select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  port 0 lane write enables.
- spare_wen0  in  1  port 0 spare-bit write enable.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH+SPARE_BITS  port 0 write data; spare bits in the MSBs.
- dout0  out  DATA_WIDTH+SPARE_BITS  port 0 read data.
- dout0_valid  out  1  port 0 read data valid, one-cycle pulse per read.
- err0  out  1  port 0 out-of-range access, one-cycle pulse.
- csb1  in  1  port 1 active-low select.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH+SPARE_BITS  port 1 read data.
- dout1_valid  out  1  port 1 read data valid pulse.
- err1  out  1  port 1 out-of-range read, one-cycle pulse.
- collision1  out  1  asserted alongside dout1_valid when the read collided with a port-0 write.

Behaviour:
- Reset (rst0_n=0, asynchronous): dout0, dout1, dout0_valid, dout1_valid, err0, err1 and collision1 clear to 0, and all read-pipeline stages clear. Array contents are preserved.
- Reset asserted mid-operation: in-flight reads are discarded and never emerge after reset deasserts.
- Port-0 write, sampled at edge N (csb0=0, web0=0): for each lane i with wmask0[i]=1, word[addr0] bits [i*LANE_WIDTH +: LANE_WIDTH] are updated. Spare bits are updated only if spare_wen0=1.
  - An all-zero mask with spare_wen0=0 is a legal no-op.
  - A write produces no dout0_valid, and dout0 holds its value.
- Port-0 read, sampled at edge N (csb0=0, web0=1): dout0 is loaded at edge N+READ_LATENCY-1 and is visible in cycle N+READ_LATENCY. dout0_valid is high in that same cycle only.
- Port-1 read follows the same timing as a port-0 read.
- Back-to-back reads on consecutive cycles are fully pipelined, giving one result per cycle in request order. dout holds its last value when valid is low.
- Out-of-range address (addr >= RAM_DEPTH):
  - Writes are dropped.
  - Reads return 0 with valid=1.
  - err pulses together with that valid, or with the sampled write one cycle after edge N.
- Collision (port-0 write and port-1 read of the same in-range address in the same edge):
  - COLLISION_MODE=0: dout1 returns pre-write data.
  - COLLISION_MODE=1: dout1 returns the post-merge word.
  - In both modes collision1=1 with that dout1_valid.
- A port-1 read one edge after a write to the same address always returns the new data.
- A port-0 read cannot collide with itself.
- csb=1: the port is idle and its address/data inputs are ignored.

Decomposition:
- Package sram_model_pkg holds:
  - COLLISION_OLD = 0 and COLLISION_NEW = 1 constants;
  - MAX_READ_LATENCY = 3;
  - a function returning NUM_WMASKS from DATA_WIDTH and LANE_WIDTH.
- Sub-module sram_rd_pipe: a parametrised latency shift register carrying data, valid, err and collision. It is instantiated once per read port and takes the same async active-low reset.
- The array and write merge stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF with spare=1, mask 4'hF, spare_wen0=1, to addr0=5; read addr0=5 -> dout0=33'h1DEADBEEF with dout0_valid 1 cycle after the sampled read (READ_LATENCY=1).
- Partial write of 0x11223344 with mask 4'b0101 over 0xAABBCCDD at addr 7; read port 1 -> dout1=0xAA22CC44.
- Same-edge write of 0x12345678 to addr 3 (old 0) with a port-1 read of addr 3:
  - COLLISION_MODE=0 -> dout1=0 and collision1=1.
  - COLLISION_MODE=1 -> dout1=0x12345678 and collision1=1.
- READ_LATENCY=3, reads of addrs 0,1,2 on consecutive cycles -> three valid pulses on consecutive cycles 3 cycles later, in order. Assert rst0_n=0 mid-stream -> no valid pulses after release, and memory still holds the previous data.
- RAM_DEPTH=500, write to addr 510 then read addr 510 -> write dropped, err0 pulses, and the read returns 0 with dout0_valid=1 and err0=1.
- csb0=1 with web0=0 and random data -> no array change and no valid pulse.
